// File: rtl/matmul_ctrl_pkg.sv
// Shared types and default geometry for the matrix-multiply sequencer.
package matmul_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    localparam int K_DEF       = 4;
    localparam int ROWS_DEF    = 4;
    localparam int ALU_LAT_DEF = 2;
    localparam int ADDR_W_DEF  = 8;
    localparam int ROM_AW      = 4;

    // Counter width for a modulus, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N up counter with enable, synchronous clear and a terminal-count flag.
module mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count,
    output logic             o_wrap
);

    logic [WIDTH-1:0] r_count;
    logic             w_last;

    assign w_last = (r_count == WIDTH'(MODULUS - 1));

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_last ? '0 : r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_wrap  = i_en & w_last;

endmodule

// File: rtl/matmul_ctrl.sv
// Sequencer for one matrix-multiply frame: load X, MAC/drain/write each output row.
module matmul_ctrl
    import matmul_ctrl_pkg::*;
#(
    parameter int K       = K_DEF,
    parameter int ROWS    = ROWS_DEF,
    parameter int ALU_LAT = ALU_LAT_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              xload_done,
    input  logic              ram_ry,
    output logic              input_load_en,
    output logic              alu_en,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              x_shift,
    output logic              ram_cs_n,
    output logic              ram_we_n,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              busy,
    output logic              row_done,
    output logic              frame_done
);

    localparam int CW = cnt_w(K);
    localparam int RW = cnt_w(ROWS);
    localparam int DW = cnt_w(ALU_LAT);

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;

    logic [CW-1:0] w_col;
    logic          w_col_wrap;
    logic [RW-1:0] w_row;
    logic          w_row_wrap;
    logic [DW-1:0] w_drain_unused;
    logic          w_drain_wrap;
    logic          w_accept;

    assign w_accept = (r_state == S_WRITE) && ram_ry;

    mod_counter #(.WIDTH(CW), .MODULUS(K)) u_col (
        .clk(clk), .rst(rst), .i_en(r_state == S_MAC), .i_clr(r_state != S_MAC),
        .o_count(w_col), .o_wrap(w_col_wrap)
    );

    mod_counter #(.WIDTH(DW), .MODULUS(ALU_LAT)) u_drain (
        .clk(clk), .rst(rst), .i_en(r_state == S_DRAIN), .i_clr(r_state != S_DRAIN),
        .o_count(w_drain_unused), .o_wrap(w_drain_wrap)
    );

    // Row advances only on an accepted write; it wraps back to 0 on the last row.
    mod_counter #(.WIDTH(RW), .MODULUS(ROWS)) u_row (
        .clk(clk), .rst(rst), .i_en(w_accept), .i_clr(r_state == S_IDLE),
        .o_count(w_row), .o_wrap(w_row_wrap)
    );

    // NOTE: reset is sampled on the clock edge only; it is part of the synchronous next-state logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_base  <= '0;
        end else begin
            case (r_state)
                S_IDLE:  if (start) r_state <= S_LOAD;
                S_LOAD:  if (xload_done) r_state <= S_MAC;
                S_MAC:   if (w_col_wrap) r_state <= S_DRAIN;
                S_DRAIN: if (w_drain_wrap) r_state <= S_WRITE;
                S_WRITE: if (ram_ry) r_state <= w_row_wrap ? S_DONE : S_MAC;
                S_DONE: begin
                    r_base  <= r_base + ADDR_W'(ROWS);
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode state and counters; only the write-accept pulses see ram_ry.
    assign input_load_en = (r_state == S_LOAD);
    assign alu_en        = (r_state == S_MAC);
    assign rom_addr      = (r_state == S_MAC) ? ROM_AW'(int'(w_row) * K + int'(w_col)) : '0;
    assign ram_cs_n      = (r_state != S_WRITE);
    assign ram_we_n      = (r_state != S_WRITE);
    assign ram_addr      = (r_state == S_WRITE) ? r_base + ADDR_W'(w_row) : '0;
    assign busy          = (r_state != S_IDLE);
    assign row_done      = w_accept;
    assign x_shift       = w_accept;
    assign frame_done    = (r_state == S_DONE);

endmodule
